// File: rtl/led_strip_sequencer.sv
// led_strip_sequencer: command-driven sequencer for a 10-pixel, 24-bit LED strip.
// Holds the mode, color and brightness configuration and a prescaled animation step.
// It renders the registered strip image on every clock edge.
module led_strip_sequencer #(
    parameter int STEP_DIV = 4,
    parameter int NUM_PIX  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       op_code,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [9:0][23:0] strip,
    output logic [2:0]       brightness,
    output logic [1:0]       mode,
    output logic [2:0]       color_code,
    output logic             paused,
    output logic             frame_tick
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_APPLY  = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_is_color;
    logic             w_is_mode;
    logic             w_is_clear;
    logic             w_restart;
    logic             w_terminal;

    logic [1:0]       r_mode;
    logic [2:0]       r_color;
    logic [2:0]       r_bright;
    logic             r_paused;
    logic [PW-1:0]    r_presc;
    logic [3:0]       r_step;
    logic             r_tick;
    logic [9:0][23:0] r_strip;

    function automatic logic [2:0] sat_inc(input logic [2:0] b);
        return (b == 3'd7) ? b : b + 3'd1;
    endfunction

    function automatic logic [2:0] sat_dec(input logic [2:0] b);
        return (b == 3'd0) ? b : b - 3'd1;
    endfunction

    // Step wrap point depends on the mode: CHASE spans pixels 0..9, FILL spans
    // 0..10 lit pixels, SOLID and BLINK only need a two-phase toggle.
    function automatic logic [3:0] next_step(input logic [1:0] m, input logic [3:0] s);
        logic [3:0] last;
        case (m)
            2'd1:    last = 4'd9;
            2'd3:    last = 4'd10;
            default: last = 4'd1;
        endcase
        return (s >= last) ? 4'd0 : s + 4'd1;
    endfunction

    function automatic logic [9:0][23:0] render(input logic [1:0] m,
                                                input logic [2:0] c,
                                                input logic [2:0] b,
                                                input logic [3:0] s);
        logic [9:0][23:0] img;
        logic [7:0]       level;
        logic [23:0]      pix;
        logic             lit;
        level = {b, 5'b11111};
        pix   = {c[2] ? level : 8'h00, c[1] ? level : 8'h00, c[0] ? level : 8'h00};
        img   = '0;
        for (int i = 0; i < NUM_PIX; i++) begin
            case (m)
                2'd0:    lit = 1'b1;
                2'd1:    lit = (s == 4'(i));
                2'd2:    lit = (s == 4'd0);
                default: lit = (4'(i) < s);
            endcase
            img[i] = lit ? pix : 24'h000000;
        end
        return img;
    endfunction

    assign w_accept   = cmd_valid & w_cmd_ready;
    assign w_is_color = ~op_code[3];
    assign w_is_mode  = (op_code[3:2] == 2'b10);
    assign w_is_clear = (op_code == 4'b1111);
    assign w_restart  = w_accept & (w_is_color | w_is_mode | w_is_clear);
    // Uses the pause state before any command on this edge, so a pause landing
    // on the terminal count still lets this tick through.
    assign w_terminal = ~r_paused & (r_presc == PW'(STEP_DIV - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake ready; APPLY is a one-cycle bubble after each accept.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b1;
        case (r_state)
            S_RUN, S_PAUSED: begin
                if (cmd_valid) begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                w_cmd_ready = 1'b0;
                w_state_nxt = r_paused ? S_PAUSED : S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Configuration registers decoded from an accepted command.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= 2'd0;
            r_color  <= 3'd0;
            r_bright <= 3'd7;
            r_paused <= 1'b0;
        end else if (w_accept) begin
            if (w_is_color) begin
                r_color <= op_code[2:0];
            end else if (w_is_mode) begin
                r_mode <= op_code[1:0];
            end else begin
                case (op_code[1:0])
                    2'b00: r_bright <= sat_inc(r_bright);
                    2'b01: r_bright <= sat_dec(r_bright);
                    2'b10: r_paused <= ~r_paused;
                    default: begin
                        r_mode   <= 2'd0;
                        r_color  <= 3'd0;
                        r_bright <= 3'd7;
                        r_paused <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Prescaler, animation step and frame tick; a restarting command beats the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_step  <= 4'd0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_restart) begin
                r_presc <= '0;
                r_step  <= 4'd0;
            end else if (w_terminal) begin
                r_presc <= '0;
                r_step  <= next_step(r_mode, r_step);
                r_tick  <= 1'b1;
            end else if (!r_paused) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // Strip image rendered from the registered configuration and step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_strip <= '0;
        end else begin
            r_strip <= render(r_mode, r_color, r_bright, r_step);
        end
    end

    assign cmd_ready  = w_cmd_ready;
    assign strip      = r_strip;
    assign brightness = r_bright;
    assign mode       = r_mode;
    assign color_code = r_color;
    assign paused     = r_paused;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Testbench for led_strip_sequencer: command table with scoreboard plus
// hand-written animation, pause, collision and reset sequences.
module tb_led_strip_sequencer;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       op_code;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [9:0][23:0] strip;
    logic [2:0]       brightness;
    logic [1:0]       mode;
    logic [2:0]       color_code;
    logic             paused;
    logic             frame_tick;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  color;
        logic [1:0]  mode;
        logic [2:0]  bright;
        logic        paused;
        logic [23:0] pix;
    } vec_t;

    vec_t tbl[9];
    vec_t sbq[$];

    led_strip_sequencer #(.STEP_DIV(4), .NUM_PIX(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_code    (op_code),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .strip      (strip),
        .brightness (brightness),
        .mode       (mode),
        .color_code (color_code),
        .paused     (paused),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_strip(input string name, input logic [239:0] act, input logic [239:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [239:0] fill_s(input int n, input logic [23:0] p);
        logic [9:0][23:0] s;
        for (int i = 0; i < 10; i++) s[i] = (i < n) ? p : 24'h000000;
        return s;
    endfunction

    function automatic logic [239:0] chase_s(input int idx, input logic [23:0] p);
        logic [9:0][23:0] s;
        for (int i = 0; i < 10; i++) s[i] = (i == idx) ? p : 24'h000000;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Returns one step after the accept edge.
    task automatic send_cmd(input logic [3:0] op);
        int w;
        op_code   = op;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 8) begin
            tick();
            w++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: cmd_ready stayed %0b for op %b", cmd_ready, op);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        vec_t             e;
        logic [239:0]     prev;
        sbq.push_back(v);
        prev = strip;
        send_cmd(v.op);
        e = sbq.pop_front();
        chk({name, "_color"},  32'(color_code), 32'(e.color));
        chk({name, "_mode"},   32'(mode),       32'(e.mode));
        chk({name, "_bright"}, 32'(brightness), 32'(e.bright));
        chk({name, "_paused"}, 32'(paused),     32'(e.paused));
        chk({name, "_ready_apply"}, 32'(cmd_ready), 32'(0));
        chk_strip({name, "_strip_hold"}, strip, prev);
        tick();
        chk({name, "_ready_back"}, 32'(cmd_ready), 32'(1));
        chk_strip({name, "_strip"}, strip, fill_s(10, e.pix));
    endtask

    initial begin
        logic [2:0] exp_b;
        logic [7:0] lvl;
        vec_t       v;

        tbl[0] = '{op: 4'b0100, color: 3'd4, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'hFF0000};
        tbl[1] = '{op: 4'b0111, color: 3'd7, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'hFFFFFF};
        tbl[2] = '{op: 4'b1101, color: 3'd7, mode: 2'd0, bright: 3'd6, paused: 1'b0, pix: 24'hDFDFDF};
        tbl[3] = '{op: 4'b1101, color: 3'd7, mode: 2'd0, bright: 3'd5, paused: 1'b0, pix: 24'hBFBFBF};
        tbl[4] = '{op: 4'b1100, color: 3'd7, mode: 2'd0, bright: 3'd6, paused: 1'b0, pix: 24'hDFDFDF};
        tbl[5] = '{op: 4'b0011, color: 3'd3, mode: 2'd0, bright: 3'd6, paused: 1'b0, pix: 24'h00DFDF};
        tbl[6] = '{op: 4'b1111, color: 3'd0, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'h000000};
        tbl[7] = '{op: 4'b0001, color: 3'd1, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'h0000FF};
        tbl[8] = '{op: 4'b1000, color: 3'd1, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'h0000FF};

        // Reset held with a pending command.
        rst       = 1'b1;
        cmd_valid = 1'b1;
        op_code   = 4'b0100;
        ticks(2);
        chk("rst_color",  32'(color_code), 32'(0));
        chk("rst_mode",   32'(mode),       32'(0));
        chk("rst_bright", 32'(brightness), 32'(7));
        chk("rst_ready",  32'(cmd_ready),  32'(1));
        chk("rst_paused", 32'(paused),     32'(0));
        chk("rst_tick",   32'(frame_tick), 32'(0));
        chk_strip("rst_strip", strip, fill_s(0, 24'h0));
        cmd_valid = 1'b0;
        rst       = 1'b0;
        tick();

        // Command table.
        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Brightness saturation down then up.
        exp_b = 3'd7;
        v = '{op: 4'b0111, color: 3'd7, mode: 2'd0, bright: 3'd7, paused: 1'b0, pix: 24'hFFFFFF};
        run_vec(v, "white");
        for (int i = 0; i < 8; i++) begin
            exp_b = (exp_b == 3'd0) ? 3'd0 : exp_b - 3'd1;
            lvl   = {exp_b, 5'b11111};
            v = '{op: 4'b1101, color: 3'd7, mode: 2'd0, bright: exp_b, paused: 1'b0, pix: {lvl, lvl, lvl}};
            run_vec(v, $sformatf("bdec%0d", i));
        end
        chk("bdec_floor", 32'(brightness), 32'(0));
        chk_strip("bdec_floor_strip", strip, fill_s(10, 24'h1F1F1F));
        for (int i = 0; i < 9; i++) begin
            exp_b = (exp_b == 3'd7) ? 3'd7 : exp_b + 3'd1;
            lvl   = {exp_b, 5'b11111};
            v = '{op: 4'b1100, color: 3'd7, mode: 2'd0, bright: exp_b, paused: 1'b0, pix: {lvl, lvl, lvl}};
            run_vec(v, $sformatf("binc%0d", i));
        end
        chk_strip("binc_ceiling_strip", strip, fill_s(10, 24'hFFFFFF));

        // Chase over 44 cycles.
        do_reset();
        send_cmd(4'b0010);
        send_cmd(4'b1001);
        chk("chase_mode", 32'(mode), 32'(1));
        for (int k = 1; k <= 44; k++) begin
            tick();
            chk_strip($sformatf("chase_strip_%0d", k), strip, chase_s(((k - 1) / 4) % 10, 24'h00FF00));
            chk($sformatf("chase_tick_%0d", k), 32'(frame_tick), 32'((k % 4) == 0));
        end

        // Pause in FILL mode.
        do_reset();
        send_cmd(4'b0111);
        send_cmd(4'b1011);
        ticks(9);
        chk_strip("fill_pre_pause", strip, fill_s(2, 24'hFFFFFF));
        send_cmd(4'b1110);
        chk("pause_on", 32'(paused), 32'(1));
        for (int k = 0; k < 30; k++) begin
            tick();
            chk_strip($sformatf("pause_strip_%0d", k), strip, fill_s(2, 24'hFFFFFF));
            chk($sformatf("pause_tick_%0d", k), 32'(frame_tick), 32'(0));
        end
        send_cmd(4'b1110);
        chk("pause_off", 32'(paused), 32'(0));
        tick();
        chk_strip("resume_hold", strip, fill_s(2, 24'hFFFFFF));
        chk("resume_tick_early", 32'(frame_tick), 32'(0));
        tick();
        chk("resume_tick", 32'(frame_tick), 32'(1));
        tick();
        chk_strip("resume_strip", strip, fill_s(3, 24'hFFFFFF));
        ticks(2);
        send_cmd(4'b1101);
        chk("bright_on_tc_tick", 32'(frame_tick), 32'(1));
        chk("bright_on_tc_value", 32'(brightness), 32'(6));
        tick();
        chk_strip("bright_on_tc_strip", strip, fill_s(4, 24'hDFDFDF));
        ticks(2);
        send_cmd(4'b1110);
        chk("pause_on_tc_tick", 32'(frame_tick), 32'(1));
        chk("pause_on_tc_paused", 32'(paused), 32'(1));
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("pause2_tick_%0d", k), 32'(frame_tick), 32'(0));
        end
        chk_strip("pause2_strip", strip, fill_s(5, 24'hDFDFDF));

        // Mode command on the terminal-count edge, then reset mid-animation.
        do_reset();
        send_cmd(4'b0111);
        send_cmd(4'b1011);
        ticks(7);
        send_cmd(4'b1011);
        chk("collide_tick", 32'(frame_tick), 32'(0));
        chk("collide_mode", 32'(mode), 32'(3));
        tick();
        chk_strip("collide_strip", strip, fill_s(0, 24'hFFFFFF));
        ticks(3);
        chk("collide_next_tick", 32'(frame_tick), 32'(1));
        tick();
        chk_strip("collide_step1", strip, fill_s(1, 24'hFFFFFF));
        ticks(23);
        chk_strip("pre_reset_strip", strip, fill_s(6, 24'hFFFFFF));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_strip("midrst_strip", strip, fill_s(0, 24'h0));
        chk("midrst_mode",   32'(mode),       32'(0));
        chk("midrst_color",  32'(color_code), 32'(0));
        chk("midrst_bright", 32'(brightness), 32'(7));
        chk("midrst_tick",   32'(frame_tick), 32'(0));
        chk("midrst_ready",  32'(cmd_ready),  32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
